// File: rtl/knight_rider_scanner_pkg.sv
// Shared constants for the knight-rider scanner: direction/mode encodings,
// FSM state codes and a helper for sizing the position register.
package knight_rider_scanner_pkg;

    localparam logic DIR_UP      = 1'b0;
    localparam logic DIR_DOWN    = 1'b1;
    localparam logic MODE_BOUNCE = 1'b0;
    localparam logic MODE_WRAP   = 1'b1;

    // The FSM state is the direction bit, so the state register drives dir directly
    localparam logic STATE_UP    = DIR_UP;
    localparam logic STATE_DOWN  = DIR_DOWN;

    function automatic int pos_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Programmable prescaler: emits a one-cycle tick every (period+1) enabled cycles.
module tick_gen #(
    parameter int PRESCALE_W = 24
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] period,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] count_reg;

    // >= rather than == so a period lowered below the running count ticks at once
    assign tick = en && !clr && (count_reg >= period);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= tick ? '0 : count_reg + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/knight_rider_scanner.sv
// One-hot LED scanner: a single lit bit sweeps the bus in bounce or wrap mode,
// stepping on each prescaler tick.
module knight_rider_scanner
    import knight_rider_scanner_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 24
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  en,
    input  logic                  restart,
    input  logic                  mode,
    input  logic [PRESCALE_W-1:0] period,
    output logic [WIDTH-1:0]      leds,
    output logic                  dir,
    output logic                  step,
    output logic                  sweep_done
);

    localparam int               POS_W   = pos_width(WIDTH);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(WIDTH - 1);
    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

    logic             tick;
    logic [POS_W-1:0] pos_reg, pos_next;
    logic             state_reg, state_next;
    logic [WIDTH-1:0] leds_reg, leds_next;
    logic             step_reg;
    logic             sweep_reg, sweep_next;

    tick_gen #(
        .PRESCALE_W (PRESCALE_W)
    ) u_tick_gen (
        .clk     (clk),
        .aresetn (aresetn),
        .en      (en),
        .clr     (restart),
        .period  (period),
        .tick    (tick)
    );

    always_comb begin
        pos_next   = pos_reg;
        state_next = state_reg;
        sweep_next = 1'b0;
        if (tick) begin
            if (mode == MODE_WRAP) begin
                // Wrap always moves up, even if we arrive here heading down
                state_next = STATE_UP;
                if (pos_reg == POS_MAX) begin
                    pos_next   = '0;
                    sweep_next = 1'b1;
                end else begin
                    pos_next = pos_reg + POS_ONE;
                end
            end else begin
                case (state_reg)
                    STATE_UP: begin
                        if (pos_reg == POS_MAX) begin
                            state_next = STATE_DOWN;
                            pos_next   = POS_MAX - POS_ONE;
                        end else begin
                            pos_next = pos_reg + POS_ONE;
                        end
                    end
                    default: begin
                        if (pos_reg == '0) begin
                            state_next = STATE_UP;
                            pos_next   = POS_ONE;
                            sweep_next = 1'b1;
                        end else begin
                            pos_next = pos_reg - POS_ONE;
                        end
                    end
                endcase
            end
        end
    end

    // One-hot decode of the next position so leds is a plain register
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_led_decode
            assign leds_next[gi] = (pos_next == POS_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            pos_reg   <= '0;
            state_reg <= STATE_UP;
            leds_reg  <= WIDTH'(1);
            step_reg  <= 1'b0;
            sweep_reg <= 1'b0;
        end else if (restart) begin
            pos_reg   <= '0;
            state_reg <= STATE_UP;
            leds_reg  <= WIDTH'(1);
            step_reg  <= 1'b0;
            sweep_reg <= 1'b0;
        end else begin
            pos_reg   <= pos_next;
            state_reg <= state_next;
            leds_reg  <= leds_next;
            step_reg  <= tick;
            sweep_reg <= sweep_next;
        end
    end

    assign leds       = leds_reg;
    assign dir        = state_reg;
    assign step       = step_reg;
    assign sweep_done = sweep_reg;

endmodule

// File: tb/tb_knight_rider_scanner.sv
// Directed bench for knight_rider_scanner (WIDTH=8): bounce, wrap, prescaler,
// freeze, restart priority, async reset and mid-count period change.
module tb_knight_rider_scanner;

    logic        clk     = 1'b0;
    logic        aresetn = 1'b0;
    logic        en      = 1'b0;
    logic        restart = 1'b0;
    logic        mode    = 1'b0;
    logic [23:0] period  = '0;
    logic [7:0]  leds;
    logic        dir;
    logic        step;
    logic        sweep_done;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses;

    logic [7:0] exp_b [16];
    logic [7:0] exp_w [9];

    always #5 clk = ~clk;

    knight_rider_scanner #(
        .WIDTH      (8),
        .PRESCALE_W (24)
    ) dut (
        .clk        (clk),
        .aresetn    (aresetn),
        .en         (en),
        .restart    (restart),
        .mode       (mode),
        .period     (period),
        .leds       (leds),
        .dir        (dir),
        .step       (step),
        .sweep_done (sweep_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled on the falling edge
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        exp_b = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                  8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
        exp_w = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};

        // Reset state
        repeat (2) cyc();
        check("rst_leds", 32'(leds), 32'h01);
        check("rst_dir", 32'(dir), 32'h0);
        check("rst_step", 32'(step), 32'h0);
        check("rst_sweep", 32'(sweep_done), 32'h0);

        // Bounce, period 0
        aresetn = 1'b1;
        en      = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc();
            check($sformatf("bounce_leds[%0d]", i), 32'(leds), 32'(exp_b[i]));
            check($sformatf("bounce_dir[%0d]", i), 32'(dir), (i >= 7 && i <= 13) ? 32'h1 : 32'h0);
            check($sformatf("bounce_sweep[%0d]", i), 32'(sweep_done), (i == 14) ? 32'h1 : 32'h0);
            check($sformatf("bounce_step[%0d]", i), 32'(step), 32'h1);
        end

        // Run to 40 heading down, then async reset mid-cycle
        repeat (6) cyc();
        check("pre_rst_leds", 32'(leds), 32'h40);
        check("pre_rst_dir", 32'(dir), 32'h1);
        #2 aresetn = 1'b0;
        #1;
        check("async_rst_leds", 32'(leds), 32'h01);
        check("async_rst_dir", 32'(dir), 32'h0);
        check("async_rst_step", 32'(step), 32'h0);
        @(negedge clk);
        aresetn = 1'b1;

        // period=3: one step every 4 clocks
        period  = 24'd3;
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        for (int k = 0; k < 16; k++) begin
            cyc();
            check($sformatf("p3_step[%0d]", k), 32'(step), (k % 4 == 3) ? 32'h1 : 32'h0);
        end
        check("p3_leds", 32'(leds), 32'h10);

        // Freeze for 10 clocks
        en     = 1'b0;
        pulses = 0;
        repeat (10) begin
            cyc();
            pulses += int'(step);
        end
        check("freeze_pulses", 32'(pulses), 32'h0);
        check("freeze_leds", 32'(leds), 32'h10);
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check($sformatf("resume_step[%0d]", k), 32'(step), (k == 3) ? 32'h1 : 32'h0);
        end
        check("resume_leds", 32'(leds), 32'h20);

        // Restart with a same-cycle tick
        restart = 1'b1;
        period  = 24'd0;
        cyc();
        restart = 1'b0;
        check("restart_leds", 32'(leds), 32'h01);
        check("restart_dir", 32'(dir), 32'h0);
        check("restart_step", 32'(step), 32'h0);

        // Wrap, period 0
        mode = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cyc();
            check($sformatf("wrap_leds[%0d]", i), 32'(leds), 32'(exp_w[i]));
            check($sformatf("wrap_sweep[%0d]", i), 32'(sweep_done), (i == 7) ? 32'h1 : 32'h0);
            check($sformatf("wrap_dir[%0d]", i), 32'(dir), 32'h0);
        end

        // Bounce down to 10, then switch to wrap
        mode = 1'b0;
        repeat (9) cyc();
        check("sw_pre_leds", 32'(leds), 32'h10);
        check("sw_pre_dir", 32'(dir), 32'h1);
        mode = 1'b1;
        cyc();
        check("sw_wrap_leds", 32'(leds), 32'h20);
        check("sw_wrap_dir", 32'(dir), 32'h0);
        check("sw_wrap_step", 32'(step), 32'h1);

        // Lower period 100 -> 2 while count is 50
        mode    = 1'b0;
        period  = 24'd100;
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        check("p100_leds", 32'(leds), 32'h01);
        pulses = 0;
        repeat (50) begin
            cyc();
            pulses += int'(step);
        end
        check("p100_pulses", 32'(pulses), 32'h0);
        period = 24'd2;
        cyc();
        check("lower_step", 32'(step), 32'h1);
        check("lower_leds", 32'(leds), 32'h02);
        for (int k = 0; k < 6; k++) begin
            cyc();
            check($sformatf("p2_step[%0d]", k), 32'(step), (k % 3 == 2) ? 32'h1 : 32'h0);
        end
        check("p2_leds", 32'(leds), 32'h08);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
